// File: rtl/xt_gradient_mac_seq_if.sv
// Handshake/operand bundle for the X^T * (X*theta - Y) gradient sequencer.
interface xt_gradient_mac_seq_if #(
  parameter int M  = 20,
  parameter int N  = 3,
  parameter int XW = 16,
  parameter int EW = 32,
  parameter int GW = 32
) ();
  logic                start;
  logic [XW*N*M-1:0]   XT;
  logic [EW*M-1:0]     Xtheta_Y;
  logic                busy;
  logic                grad_valid;
  logic                grad_ready;
  logic [GW*N-1:0]     gradient_vector;
  logic [N-1:0]        overflow;

  modport master (
    output start, XT, Xtheta_Y, grad_ready,
    input  busy, grad_valid, gradient_vector, overflow
  );

  modport slave (
    input  start, XT, Xtheta_Y, grad_ready,
    output busy, grad_valid, gradient_vector, overflow
  );
endinterface

// File: rtl/xt_gradient_mac_seq.sv
// Sequential gradient MAC: one column of XT per cycle, N feature lanes in
// parallel, result narrowed (saturate or wrap) and held behind valid/ready.

// One feature lane: wide accumulator plus GW-bit narrowing of its value.
module xt_gradient_mac_lane #(
  parameter int XW  = 16,
  parameter int EW  = 32,
  parameter int GW  = 32,
  parameter int AW  = 54,
  parameter int SAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [XW-1:0] x,
  input  logic signed [EW-1:0] e,
  output logic [GW-1:0]        res,
  output logic                 ovf
);
  // Width used for the fit test; covers GW wider than the accumulator too.
  localparam int WW = (AW > GW) ? AW : GW;

  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [XW+EW-1:0] prod;
  logic signed [WW-1:0]    ext;
  logic                    fits;

  assign prod = x * e;

  // Accumulator next value: clear on capture, add product while accumulating.
  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + AW'(prod);
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Narrow to GW: fits when every bit above the GW sign bit matches it.
  always_comb begin
    ext  = WW'(acc_q);
    fits = (ext[WW-1:GW-1] == {(WW-GW+1){ext[GW-1]}});
    ovf  = ~fits;
    res  = ext[GW-1:0];
    if (!fits && SAT != 0)
      res = ext[WW-1] ? {1'b1, {(GW-1){1'b0}}} : {1'b0, {(GW-1){1'b1}}};
  end
endmodule

module xt_gradient_mac_seq #(
  parameter int M   = 20,
  parameter int N   = 3,
  parameter int XW  = 16,
  parameter int EW  = 32,
  parameter int GW  = 32,
  parameter int SAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  xt_gradient_mac_seq_if.slave  bus
);
  localparam int AW = XW + EW + $clog2(M) + 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       i_q, i_d;
  logic [XW*N*M-1:0]   xt_q, xt_d;
  logic [EW*M-1:0]     e_q, e_d;
  logic                grad_valid_q, grad_valid_d;
  logic [GW*N-1:0]     gv_q, gv_d;
  logic [N-1:0]        ovf_q, ovf_d;
  logic                busy;

  logic                last_i, lane_clr, lane_en;
  logic [XW*N*M-1:0]   xt_sh;
  logic [EW*M-1:0]     e_sh;
  logic [N-1:0][XW-1:0] x_sel;
  logic [N-1:0][EW-1:0] e_rep;
  logic [N-1:0][GW-1:0] lane_res;
  logic [N-1:0]         lane_ovf;

  assign last_i   = (i_q == IW'(M - 1));
  assign lane_clr = (state_q == IDLE) && bus.start;
  assign lane_en  = (state_q == ACC);

  // Pick column i of the captured matrix for every lane, plus e(i).
  always_comb begin
    xt_sh = '0;
    e_sh  = e_q >> (EW * (M - 1 - int'(i_q)));
    for (int j = 0; j < N; j++) begin
      xt_sh    = xt_q >> (XW * (N*M - 1 - j*M - int'(i_q)));
      x_sel[j] = xt_sh[XW-1:0];
      e_rep[j] = e_sh[EW-1:0];
    end
  end

  xt_gradient_mac_lane #(
    .XW(XW), .EW(EW), .GW(GW), .AW(AW), .SAT(SAT)
  ) u_lane [N-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lane_clr),
    .en    (lane_en),
    .x     (x_sel),
    .e     (e_rep),
    .res   (lane_res),
    .ovf   (lane_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: capture, walk M columns, wait for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACC;
      ACC:     if (last_i) state_d = OUT;
      OUT:     if (grad_valid_q && bus.grad_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy covers accumulation and result hold.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next values: operand capture, column index, result load/handoff.
  // Results are loaded on the first OUT cycle, after the last lane add lands.
  always_comb begin
    xt_d         = xt_q;
    e_d          = e_q;
    i_d          = i_q;
    grad_valid_d = grad_valid_q;
    gv_d         = gv_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        xt_d = bus.XT;
        e_d  = bus.Xtheta_Y;
        i_d  = '0;
      end
      ACC: i_d = last_i ? '0 : i_q + 1'b1;
      OUT: begin
        if (!grad_valid_q) begin
          grad_valid_d = 1'b1;
          ovf_d        = lane_ovf;
          for (int j = 0; j < N; j++) gv_d[GW*(N-j)-1 -: GW] = lane_res[j];
        end else if (bus.grad_ready) begin
          grad_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xt_q         <= '0;
      e_q          <= '0;
      i_q          <= '0;
      grad_valid_q <= 1'b0;
      gv_q         <= '0;
      ovf_q        <= '0;
    end else begin
      xt_q         <= xt_d;
      e_q          <= e_d;
      i_q          <= i_d;
      grad_valid_q <= grad_valid_d;
      gv_q         <= gv_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.busy            = busy;
  assign bus.grad_valid      = grad_valid_q;
  assign bus.gradient_vector = gv_q;
  assign bus.overflow        = ovf_q;
endmodule

// File: tb/tb_xt_gradient_mac_seq.sv
// Bench for xt_gradient_mac_seq: saturating and wrapping instances share
// stimulus; results compared against a plain-arithmetic dot-product model.
module tb_xt_gradient_mac_seq;
  localparam int M = 20, N = 3, XW = 16, EW = 32, GW = 32;
  localparam longint GMAX = (longint'(1) <<< (GW-1)) - 1;
  localparam longint GMIN = -(longint'(1) <<< (GW-1));

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, ready = 1'b0;
  logic [XW*N*M-1:0] xt = '0;
  logic [EW*M-1:0]   ev = '0;

  longint xa [N][M];
  longint ea [M];
  int n_chk = 0, n_fail = 0;

  xt_gradient_mac_seq_if #(.M(M), .N(N), .XW(XW), .EW(EW), .GW(GW)) if_s ();
  xt_gradient_mac_seq_if #(.M(M), .N(N), .XW(XW), .EW(EW), .GW(GW)) if_w ();

  assign if_s.start = start;  assign if_w.start = start;
  assign if_s.XT = xt;        assign if_w.XT = xt;
  assign if_s.Xtheta_Y = ev;  assign if_w.Xtheta_Y = ev;
  assign if_s.grad_ready = ready; assign if_w.grad_ready = ready;

  xt_gradient_mac_seq #(.M(M), .N(N), .XW(XW), .EW(EW), .GW(GW), .SAT(1))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(if_s));
  xt_gradient_mac_seq #(.M(M), .N(N), .XW(XW), .EW(EW), .GW(GW), .SAT(0))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain dot products, then clamp / truncate to GW bits.
  task automatic model(output logic [GW*N-1:0] es, output logic [GW*N-1:0] ew,
                       output logic [N-1:0] eo);
    es = '0; ew = '0; eo = '0;
    for (int j = 0; j < N; j++) begin
      longint s = 0;
      for (int i = 0; i < M; i++) s += xa[j][i] * ea[i];
      eo[j] = (s > GMAX) || (s < GMIN);
      ew[GW*(N-j)-1 -: GW] = GW'(s);
      es[GW*(N-j)-1 -: GW] = (s > GMAX) ? GW'(GMAX) : (s < GMIN) ? GW'(GMIN) : GW'(s);
    end
  endtask

  task automatic pack_stim();
    for (int j = 0; j < N; j++)
      for (int i = 0; i < M; i++) xt[XW*(N*M-j*M-i)-1 -: XW] = XW'(xa[j][i]);
    for (int i = 0; i < M; i++) ev[EW*(M-i)-1 -: EW] = EW'(ea[i]);
  endtask

  task automatic scramble();
    for (int k = 0; k < XW*N*M; k++) xt[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < EW*M; k++)   ev[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic fill(input longint xr0, input longint xr1, input longint xr2, input longint e0);
    for (int i = 0; i < M; i++) begin
      xa[0][i] = xr0; xa[1][i] = xr1; xa[2][i] = xr2; ea[i] = e0;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 128'(if_s.busy), 128'(0));
    chk({tag, "_vld"},  128'(if_s.grad_valid), 128'(0));
    chk({tag, "_gv"},   128'(if_s.gradient_vector), 128'(0));
    chk({tag, "_ovf"},  128'(if_s.overflow), 128'(0));
    chk({tag, "_gvw"},  128'(if_w.gradient_vector), 128'(0));
    chk({tag, "_vldw"}, 128'(if_w.grad_valid), 128'(0));
  endtask

  // One full transaction: start, latency, result, hold with ignored starts, handoff.
  task automatic run_op(input string tag, input int hold);
    logic [GW*N-1:0] es, ew;
    logic [N-1:0] eo;
    int cyc;
    model(es, ew, eo);
    @(negedge clk);
    pack_stim();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    scramble();
    chk({tag, "_busy0"}, 128'(if_s.busy), 128'(1));
    cyc = 0;
    while (!if_s.grad_valid && cyc < 200) begin
      @(posedge clk); cyc++;
      #1;
    end
    chk({tag, "_lat"}, 128'(cyc), 128'(M+1));
    chk({tag, "_gvs"}, 128'(if_s.gradient_vector), 128'(es));
    chk({tag, "_gvw"}, 128'(if_w.gradient_vector), 128'(ew));
    chk({tag, "_ovs"}, 128'(if_s.overflow), 128'(eo));
    chk({tag, "_ovw"}, 128'(if_w.overflow), 128'(eo));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      start = (k % 2 == 0);
      @(posedge clk);
      #1;
      chk({tag, "_holdv"}, 128'(if_s.grad_valid), 128'(1));
      chk({tag, "_holdg"}, 128'(if_s.gradient_vector), 128'(es));
      chk({tag, "_holdo"}, 128'(if_s.overflow), 128'(eo));
    end
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_hov"},  128'(if_s.grad_valid), 128'(0));
    chk({tag, "_hob"},  128'(if_s.busy), 128'(0));
    chk({tag, "_hobw"}, 128'(if_w.busy), 128'(0));
    chk({tag, "_keep"}, 128'(if_s.gradient_vector), 128'(es));
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 128'(if_s.busy), 128'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_idle_zero("rst");
    @(negedge clk) rst_n = 1'b1;

    fill(1, 1, 1, 1);
    run_op("all1", 0);
    fill(-1, 2, 0, 5);
    run_op("rows", 5);
    fill(32767, 32767, 32767, 2147483647);
    run_op("sat", 2);

    // Abort mid-accumulation, then a clean run must match power-up behaviour.
    fill(1, 1, 1, 1);
    @(negedge clk);
    pack_stim();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle_zero("abort");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op("post_rst", 1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++)
          xa[j][i] = (t % 2 == 0) ? longint'(shortint'($urandom))
                                  : longint'($urandom_range(0, 200)) - 100;
        ea[i] = (t % 2 == 0) ? longint'(int'($urandom))
                             : longint'($urandom_range(0, 2000)) - 1000;
      end
      run_op($sformatf("rnd%0d", t), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
